// File: rtl/countdown_sequencer.sv
// countdown_sequencer: sequences an external load/decrement counter as a programmable countdown timer
module countdown_sequencer #(
  parameter int WIDTH = 4,
  parameter int TICK_DIV = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] start_value,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] remaining,
  output logic             dec_load,
  output logic [WIDTH-1:0] dec_initial_value,
  output logic             dec_decrement,
  input  logic [WIDTH-1:0] dec_count
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] RUN = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;
  localparam logic [7:0] LAST = 8'(TICK_DIV - 1);
  if (TICK_DIV < 2 || TICK_DIV > 255) begin : g_bad_tick_div
    $error("TICK_DIV must be in 2..255");
  end
  logic [2:0] state, state_nx;
  logic [7:0] presc;
  logic [WIDTH-1:0] cap;
  logic zero, run_step, accept;
  always_comb begin
    zero = dec_count == '0;
    run_step = state == RUN && !pause && !zero;
    accept = state == IDLE && start && !abort;
    state_nx = (state != IDLE && abort) ? IDLE :
               state == IDLE ? (accept ? LOAD : IDLE) :
               state == LOAD ? SETTLE :
               state == SETTLE ? RUN :
               state == RUN ? (zero ? FINISH : RUN) :
               (AUTO_RELOAD ? LOAD : IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      presc <= '0;
      cap <= '0;
      aborted <= 1'b0;
    end else begin
      state <= state_nx;
      aborted <= state != IDLE && abort;
      cap <= accept ? start_value : cap;
      presc <= state == SETTLE ? '0 : run_step ? (presc == LAST ? '0 : presc + 8'd1) : presc;
    end
  end
  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign dec_load = state == LOAD;
  assign dec_initial_value = cap;
  assign dec_decrement = run_step && presc == LAST;
  assign remaining = dec_count;
endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
Controller that sequences the existing 4-bit load/decrement counter (`decrementer`) as a programmable countdown timer. It accepts a start request with an initial value and loads the counter. It then issues one decrement pulse every TICK_DIV clocks, supports pause and abort, and flags completion when the count reaches zero. The block sits between the system control logic and the `decrementer` instance, and is the only driver of that instance's load, decrement and initial_value inputs.

Parameters:
WIDTH, 4, width of the count and initial value; must equal the decrementer width.
TICK_DIV, 4, clocks per decrement step; legal range 2..255 (elaboration error otherwise).
AUTO_RELOAD, 0, when 1, the block reloads the captured value after each completion and keeps running until abort.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset; shared with the decrementer instance.
start  input  1  start request; sampled only in IDLE.
start_value  input  WIDTH  initial count; captured on an accepted start.
pause  input  1  level; freezes the prescaler while in RUN.
abort  input  1  level; cancels any active countdown.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse, high while in FINISH.
aborted  output  1  one-cycle registered pulse after an accepted abort.
remaining  output  WIDTH  combinational copy of dec_count.
dec_load  output  1  drives decrementer load.
dec_initial_value  output  WIDTH  drives decrementer initial_value; holds the captured value.
dec_decrement  output  1  drives decrementer decrement.
dec_count  input  WIDTH  decrementer count output.

Behaviour:
- Reset is synchronous and active-high. On reset: state=IDLE, prescaler=0, captured value=0. All outputs are 0 (remaining follows dec_count, which is also 0 after reset).
- Decrementer contract:
  - load and decrement are sampled on the rising edge of clk.
  - count reflects the change after that edge.
  - load takes priority over decrement.
  - The controller never asserts both in the same cycle.
- FSM states: IDLE, LOAD, SETTLE, RUN, FINISH. dec_load, busy and done are Moore outputs decoded from state.
- IDLE:
  - On start=1 and abort=0: capture start_value and go to LOAD.
  - Otherwise remain in IDLE.
- LOAD: dec_load=1 for exactly one cycle; next state is SETTLE.
- SETTLE: one cycle so the loaded value is visible on dec_count; clear prescaler; next state is RUN.
- RUN:
  - If dec_count==0: go to FINISH next edge; no decrement issued.
  - Otherwise, when pause=0, prescaler increments and wraps from TICK_DIV-1 to 0.
  - dec_decrement=1 (combinational) in the cycle where prescaler==TICK_DIV-1, pause=0 and dec_count!=0.
  - When pause=1, prescaler holds and dec_decrement=0.
- FINISH:
  - done=1 for one cycle.
  - Next state is LOAD if AUTO_RELOAD=1 (same captured value), else IDLE.
- Abort:
  - In any state other than IDLE, abort=1 at an edge moves the FSM to IDLE and sets aborted=1 for the following cycle.
  - No done pulse is generated. Abort takes priority over every other transition, including FINISH to LOAD.
  - Abort in IDLE has no effect and produces no aborted pulse.
- start while busy is ignored. start and abort together in IDLE: start is ignored.
- Latency:
  - Start sampled at edge E0 gives LOAD after E0, SETTLE after E1, RUN after E2.
  - The k-th decrement lands at E(2+k·TICK_DIV).
  - FINISH (done high) occurs after E(3+TICK_DIV·N) for start_value=N.
  - N=0 gives done after E3.
- Underflow: the TICK_DIV>=2 spacing guarantees dec_count is updated before the next decrement decision, so the controller never decrements a zero count.
- Reset mid-operation: both blocks return to their reset state; no done or aborted pulse.

Test Plan:
1. TICK_DIV=4, start_value=3, start pulsed at E0 -> dec_load high in cycle E0–E1 with dec_initial_value=3; remaining 3→2→1→0 at E6/E10/E14; done high only in cycle E15–E16; busy falls after E16.
2. start_value=0 -> load of 0, no dec_decrement ever asserted, done high after E3, busy low after E4.
3. start_value=5, pause=1 from E7 to E15 -> no decrements and prescaler frozen during the pause; done delayed by exactly 8 cycles versus the unpaused run (E31 instead of E23).
4. start_value=6, abort pulsed at E9 -> IDLE after E9, aborted=1 for one cycle, done never asserted, remaining stays at its value (5); a start issued in the same cycle as the abort is ignored.
5. AUTO_RELOAD=1, start_value=2, TICK_DIV=2 -> done every 8 cycles (FINISH, LOAD, SETTLE, RUN×5) for at least 3 periods; abort stops reloading with no further done.
6. start asserted while busy, and reset asserted mid-RUN -> start ignored; after reset all outputs are 0 next cycle and a new start at value 1 completes with done after E(3+TICK_DIV).
